mesh_spike_injector: RTL and testbench

- Upstream injection stage for the neuromorphic mesh. Accepts spike events from a neuron cluster or host through a valid/ready interface and buffers them in a FIFO.
- Each event is formatted into a 32-bit mesh packet and driven into one node input port (din/vin/rout side) under the mesh valid/ready handshake.
- Events with out-of-range destinations are discarded and counted.

---
 rtl/mesh_spike_injector.sv | 119 +++++++++++
 tb/tb_mesh_spike_injector.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_spike_injector.sv
// Mesh spike injector: buffers spike events in a FIFO, formats them into 32-bit
// mesh packets and drives them into a node input port under valid/ready.
module mesh_spike_injector #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              evt_valid,
  output logic                              evt_ready,
  input  logic [3:0]                        evt_dest_x,
  input  logic [3:0]                        evt_dest_y,
  input  logic [15:0]                       evt_neuron_id,
  output logic [DATA_WIDTH-1:0]             dout,
  output logic                              vout,
  input  logic                              rin,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic [15:0]                       pkt_cnt,
  output logic [15:0]                       stall_cnt,
  output logic [7:0]                        err_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  localparam logic [4:0]    COLS_L = 5'(COLS);
  localparam logic [4:0]    ROWS_L = 5'(ROWS);
  localparam logic [3:0]    SX     = 4'(SRC_X);
  localparam logic [3:0]    SY     = 4'(SRC_Y);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vout_q, vout_d;
  logic [15:0]           pkt_q, pkt_d;
  logic [15:0]           stall_q, stall_d;
  logic [7:0]            err_q, err_d;

  logic                  in_range;
  logic                  accept;
  logic                  push;
  logic                  load;
  logic [DATA_WIDTH-1:0] packet;

  // Ready depends only on the registered count: a pop never frees a slot in the same cycle.
  assign evt_ready = !rst && (count_q != FULL);

  always_comb begin
    in_range = ({1'b0, evt_dest_x} < COLS_L) && ({1'b0, evt_dest_y} < ROWS_L);
    accept   = evt_valid && evt_ready;
    push     = accept && in_range;
    load     = (!vout_q || rin) && (count_q != '0);
    packet   = {evt_dest_x, evt_dest_y, SX, SY, evt_neuron_id};

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    dout_d = dout_q;
    vout_d = vout_q;
    if (load) begin
      dout_d = mem_q[rd_ptr_q];
      vout_d = 1'b1;
    end else if (vout_q && rin) begin
      vout_d = 1'b0;
    end

    pkt_d   = (vout_q && rin) ? pkt_q + 16'd1 : pkt_q;
    stall_d = (vout_q && !rin && (stall_q != '1)) ? stall_q + 16'd1 : stall_q;
    err_d   = (accept && !in_range && (err_q != '1)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      pkt_q    <= '0;
      stall_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      pkt_q    <= pkt_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= packet;
  end

  assign dout       = dout_q;
  assign vout       = vout_q;
  assign fifo_count = count_q;
  assign pkt_cnt    = pkt_q;
  assign stall_cnt  = stall_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_mesh_spike_injector.sv
// Bench for mesh_spike_injector: vector table, hand sequences and random traffic
// checked against a queue-based reference model and an in-order scoreboard.
module tb_mesh_spike_injector;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        evt_valid = 1'b0;
  logic        evt_ready;
  logic [3:0]  evt_dest_x = '0;
  logic [3:0]  evt_dest_y = '0;
  logic [15:0] evt_neuron_id = '0;
  logic [31:0] dout;
  logic        vout;
  logic        rin = 1'b1;
  logic [3:0]  fifo_count;
  logic [15:0] pkt_cnt;
  logic [15:0] stall_cnt;
  logic [7:0]  err_cnt;

  mesh_spike_injector #(
    .DATA_WIDTH(32),
    .ROWS(ROWS),
    .COLS(COLS),
    .SRC_X(0),
    .SRC_Y(0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_dest_x(evt_dest_x),
    .evt_dest_y(evt_dest_y),
    .evt_neuron_id(evt_neuron_id),
    .dout(dout),
    .vout(vout),
    .rin(rin),
    .fifo_count(fifo_count),
    .pkt_cnt(pkt_cnt),
    .stall_cnt(stall_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of waiting packets plus the visible output slot.
  logic [31:0] mq[$];
  logic [31:0] sent[$];
  logic        m_vout  = 1'b0;
  logic [31:0] m_dout  = '0;
  logic [15:0] m_pkt   = '0;
  logic [15:0] m_stall = '0;
  logic [7:0]  m_err   = '0;
  bit          last_acc;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic [15:0] id;
    logic        rin;
    logic        e_ready;
    logic        e_vout;
    logic [31:0] e_dout;
    int          e_count;
    int          e_pkt;
    int          e_err;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [3:0] dx, input logic [3:0] dy,
                                      input logic [15:0] id);
    return {dx, dy, 4'h0, 4'h0, id};
  endfunction

  task automatic drive(input logic v, input logic [3:0] dx, input logic [3:0] dy,
                       input logic [15:0] id);
    evt_valid     = v;
    evt_dest_x    = dx;
    evt_dest_y    = dy;
    evt_neuron_id = id;
  endtask

  // One clock: check ready before the edge, advance the model, check all outputs after.
  task automatic cycle();
    logic m_ready, acc, inr;
    logic [31:0] pkt;
    #2;
    m_ready = !rst && (mq.size() != DEPTH);
    chk("evt_ready", 32'(evt_ready), 32'(m_ready));
    acc      = evt_valid && m_ready;
    last_acc = evt_valid && evt_ready;
    inr = (int'(evt_dest_x) < COLS) && (int'(evt_dest_y) < ROWS);
    pkt = fmt(evt_dest_x, evt_dest_y, evt_neuron_id);
    if (!rst && vout && rin) begin
      if (sent.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: packet %h delivered with nothing pending", dout);
      end else begin
        chk("sb_order", dout, sent.pop_front());
      end
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      sent.delete();
      m_vout = 1'b0; m_dout = '0; m_pkt = '0; m_stall = '0; m_err = '0;
    end else begin
      if (m_vout && rin) m_pkt++;
      if (m_vout && !rin && m_stall != 16'hFFFF) m_stall++;
      if (acc && !inr && m_err != 8'hFF) m_err++;
      if ((!m_vout || rin) && mq.size() != 0) begin
        m_dout = mq.pop_front();
        m_vout = 1'b1;
      end else if (m_vout && rin) begin
        m_vout = 1'b0;
      end
      if (acc && inr) begin
        mq.push_back(pkt);
        sent.push_back(pkt);
      end
    end
    #1;
    chk("vout", 32'(vout), 32'(m_vout));
    chk("dout", dout, m_dout);
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 16'd0);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard, acc_n;

    //            rst valid dx  dy  id        rin rdy vout dout          cnt pkt err
    tv[0]  = '{1'b1, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 0, 0, 0};
    tv[1]  = '{1'b1, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 0, 0, 0};
    tv[2]  = '{1'b0, 1'b1, 4'd1, 4'd1, 16'h00A5, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1, 0, 0};
    tv[3]  = '{1'b0, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h1100_00A5, 0, 0, 0};
    tv[4]  = '{1'b0, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h1100_00A5, 0, 1, 0};
    tv[5]  = '{1'b0, 1'b1, 4'd2, 4'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 32'h1100_00A5, 0, 1, 1};
    tv[6]  = '{1'b0, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h1100_00A5, 0, 1, 1};
    tv[7]  = '{1'b0, 1'b1, 4'd0, 4'd1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 32'h1100_00A5, 1, 1, 1};
    tv[8]  = '{1'b0, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h0100_BEEF, 0, 1, 1};
    tv[9]  = '{1'b0, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0100_BEEF, 0, 2, 1};
    tv[10] = '{1'b0, 1'b1, 4'd0, 4'd5, 16'h0001, 1'b1, 1'b1, 1'b0, 32'h0100_BEEF, 0, 2, 2};
    tv[11] = '{1'b0, 1'b1, 4'd15, 4'd15, 16'h0002, 1'b1, 1'b1, 1'b0, 32'h0100_BEEF, 0, 2, 3};

    for (int i = 0; i < 12; i++) begin
      rst = tv[i].rst;
      rin = tv[i].rin;
      drive(tv[i].valid, tv[i].dx, tv[i].dy, tv[i].id);
      #2;
      chk($sformatf("tv%0d_ready", i), 32'(evt_ready), 32'(tv[i].e_ready));
      cycle();
      chk($sformatf("tv%0d_vout", i), 32'(vout), 32'(tv[i].e_vout));
      chk($sformatf("tv%0d_dout", i), dout, tv[i].e_dout);
      chk($sformatf("tv%0d_count", i), 32'(fifo_count), 32'(tv[i].e_count));
      chk($sformatf("tv%0d_pkt", i), 32'(pkt_cnt), 32'(tv[i].e_pkt));
      chk($sformatf("tv%0d_err", i), 32'(err_cnt), 32'(tv[i].e_err));
    end

    // Backpressure fill, then drain in order.
    do_reset();
    rin = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'd1, 4'd0, 16'(i));
      cycle();
      if (last_acc) acc_n++;
      if (i >= 1) chk("bp_dout_stable", dout, fmt(4'd1, 4'd0, 16'd0));
    end
    chk("bp_accepts", 32'(acc_n), 32'd9);
    chk("bp_count_full", 32'(fifo_count), 32'd8);
    chk("bp_stall", 32'(stall_cnt), 32'd8);
    drive(1'b0, 4'd0, 4'd0, 16'd0);
    rin = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("drain_vout", 32'(vout), 32'd1);
      chk("drain_pkt", dout, fmt(4'd1, 4'd0, 16'(k)));
      cycle();
    end
    chk("drain_idle", 32'(vout), 32'd0);
    chk("drain_pktcnt", 32'(pkt_cnt), 32'd9);

    // Full boundary: the pop cycle must not accept; the next one must.
    do_reset();
    rin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'd0, 4'd1, 16'(100 + i));
      cycle();
    end
    rin = 1'b1;
    drive(1'b1, 4'd1, 4'd1, 16'd200);
    cycle();
    chk("full_pop_noacc", 32'(last_acc), 32'd0);
    drive(1'b1, 4'd1, 4'd1, 16'd201);
    cycle();
    chk("full_next_acc", 32'(last_acc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd0, 4'd0, 16'(202 + i));
      cycle();
    end
    drive(1'b0, 4'd0, 4'd0, 16'd0);
    for (int i = 0; i < 16; i++) cycle();
    chk("full_sb_left", 32'(sent.size()), 32'd0);
    chk("full_pktcnt", 32'(pkt_cnt), 32'd14);

    // Random stream with random backpressure, 40 events.
    do_reset();
    n = 0;
    guard = 0;
    while (n < 40 && guard < 2000) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, COLS - 1)),
            4'($urandom_range(0, ROWS - 1)), 16'(1000 + n));
      rin = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc) n++;
      guard++;
    end
    chk("wrap_sent", 32'(n), 32'd40);
    drive(1'b0, 4'd0, 4'd0, 16'd0);
    rin = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("wrap_sb_left", 32'(sent.size()), 32'd0);
    chk("wrap_pktcnt", 32'(pkt_cnt), 32'd40);

    // Reset while packets are buffered and the output is stalled.
    do_reset();
    rin = 1'b0;
    n = 0;
    guard = 0;
    while (n < 6 && guard < 20) begin
      drive(1'b1, 4'd1, 4'd0, 16'(300 + n));
      cycle();
      if (last_acc) n++;
      guard++;
    end
    chk("mr_count", 32'(fifo_count), 32'd5);
    chk("mr_vout", 32'(vout), 32'd1);
    rst = 1'b1;
    cycle();
    chk("mr_ready_in_rst", 32'(last_acc), 32'd0);
    chk("mr_vout0", 32'(vout), 32'd0);
    chk("mr_count0", 32'(fifo_count), 32'd0);
    chk("mr_pkt0", 32'(pkt_cnt), 32'd0);
    chk("mr_stall0", 32'(stall_cnt), 32'd0);
    chk("mr_err0", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 16'd0);
    #2;
    chk("mr_ready_after", 32'(evt_ready), 32'd1);
    cycle();
    chk("mr_vout_after", 32'(vout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
